// File: rtl/cpu_ctrl_pkg.sv
// rtl/cpu_ctrl_pkg.sv - shared encodings for the multicycle ARM-subset controller
package cpu_ctrl_pkg;

    // Controller states; the numeric value is exported on the debug state port
    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9
    } state_t;

    typedef enum logic [2:0] {
        ALU_ADD   = 3'b000,
        ALU_SUB   = 3'b001,
        ALU_AND   = 3'b010,
        ALU_ORR   = 3'b011,
        ALU_PASSB = 3'b100
    } alu_ctrl_t;

    // ALU operand B select
    localparam logic [1:0] SRCB_RM   = 2'b00;
    localparam logic [1:0] SRCB_EXT  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    // Writeback result select
    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_RDATA  = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    // Instruction classes (instr[27:26])
    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;
    localparam logic [1:0] OP_UND = 2'b11;

    // Condition codes (instr[31:28])
    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;
    localparam logic [3:0] COND_NV = 4'b1111;

    // Data-processing commands (instr[24:21])
    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_CMP = 4'b1010;
    localparam logic [3:0] CMD_ORR = 4'b1100;
    localparam logic [3:0] CMD_MOV = 4'b1101;

    // Commands outside the supported set behave as NOPs
    function automatic logic dp_cmd_valid(input logic [3:0] cmd);
        return (cmd == CMD_AND) || (cmd == CMD_SUB) || (cmd == CMD_ADD) ||
               (cmd == CMD_CMP) || (cmd == CMD_ORR) || (cmd == CMD_MOV);
    endfunction

    function automatic alu_ctrl_t dp_alu_ctrl(input logic [3:0] cmd);
        alu_ctrl_t ctrl;
        case (cmd)
            CMD_ADD: ctrl = ALU_ADD;
            CMD_SUB: ctrl = ALU_SUB;
            CMD_CMP: ctrl = ALU_SUB;
            CMD_AND: ctrl = ALU_AND;
            CMD_ORR: ctrl = ALU_ORR;
            CMD_MOV: ctrl = ALU_PASSB;
            default: ctrl = ALU_ADD;
        endcase
        return ctrl;
    endfunction

    // Only arithmetic commands produce meaningful carry/overflow
    function automatic logic dp_updates_cv(input logic [3:0] cmd);
        return (cmd == CMD_ADD) || (cmd == CMD_SUB) || (cmd == CMD_CMP);
    endfunction

endpackage

// File: rtl/cond_unit.sv
// rtl/cond_unit.sv - evaluates an ARM condition field against stored NZCV flags
module cond_unit
    import cpu_ctrl_pkg::*;
(
    input  logic [3:0] i_cond,
    input  logic [3:0] i_flags,
    output logic       o_cond_ex
);

    logic w_n;
    logic w_z;
    logic w_c;
    logic w_v;

    assign w_n = i_flags[3];
    assign w_z = i_flags[2];
    assign w_c = i_flags[1];
    assign w_v = i_flags[0];

    // Condition truth table; 1111 never executes
    always_comb begin
        o_cond_ex = 1'b0;
        case (i_cond)
            COND_EQ: o_cond_ex = w_z;
            COND_NE: o_cond_ex = ~w_z;
            COND_CS: o_cond_ex = w_c;
            COND_CC: o_cond_ex = ~w_c;
            COND_MI: o_cond_ex = w_n;
            COND_PL: o_cond_ex = ~w_n;
            COND_VS: o_cond_ex = w_v;
            COND_VC: o_cond_ex = ~w_v;
            COND_HI: o_cond_ex = w_c & ~w_z;
            COND_LS: o_cond_ex = ~w_c | w_z;
            COND_GE: o_cond_ex = (w_n == w_v);
            COND_LT: o_cond_ex = (w_n != w_v);
            COND_GT: o_cond_ex = ~w_z & (w_n == w_v);
            COND_LE: o_cond_ex = w_z | (w_n != w_v);
            COND_AL: o_cond_ex = 1'b1;
            COND_NV: o_cond_ex = 1'b0;
            default: o_cond_ex = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - FSM, main decoder and NZCV register for the multicycle CPU
module multicycle_controller
    import cpu_ctrl_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [31:0] i_instr,
    input  logic [3:0]  i_alu_flags,
    input  logic        i_mem_ready,
    output logic        o_pc_write,
    output logic        o_ir_write,
    output logic        o_reg_write,
    output logic        o_mem_write,
    output logic        o_adr_src,
    output logic        o_alu_src_a,
    output logic [1:0]  o_alu_src_b,
    output logic [1:0]  o_result_src,
    output logic [2:0]  o_alu_ctrl,
    output logic [1:0]  o_imm_src,
    output logic [1:0]  o_reg_src,
    output logic [3:0]  o_flags,
    output logic [3:0]  o_state
);

    state_t    r_state;
    state_t    w_next_state;
    logic [3:0] r_flags;

    logic [1:0] w_op;
    logic       w_i;
    logic [3:0] w_cmd;
    logic       w_sl;
    logic       w_u;
    logic [3:0] w_cond;
    logic       w_cond_ex;
    logic       w_cmd_valid;
    logic       w_is_cmp;
    logic       w_unused_instr;

    logic       w_pc_write;
    logic       w_ir_write;
    logic       w_reg_write;
    logic       w_mem_write;
    logic       w_flag_write;
    logic       w_adr_src;
    logic       w_alu_src_a;
    logic [1:0] w_alu_src_b;
    logic [1:0] w_result_src;
    alu_ctrl_t  w_alu_ctrl;

    assign w_cond      = i_instr[31:28];
    assign w_op        = i_instr[27:26];
    assign w_i         = i_instr[25];
    assign w_cmd       = i_instr[24:21];
    assign w_u         = i_instr[23];
    assign w_sl        = i_instr[20];
    assign w_cmd_valid = dp_cmd_valid(w_cmd);
    assign w_is_cmp    = (w_cmd == CMD_CMP);

    // Register numbers and immediates are consumed by the datapath, not here
    assign w_unused_instr = ^{i_instr[22], i_instr[19:0]};

    cond_unit u_cond_unit (
        .i_cond    (w_cond),
        .i_flags   (r_flags),
        .o_cond_ex (w_cond_ex)
    );

    // State register; reset aborts any instruction in flight
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next_state;
        end
    end

    // NZCV register; written only on the edge that ends EXECUTE
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_flags <= 4'b0000;
        end else if (w_flag_write) begin
            r_flags[3:2] <= i_alu_flags[3:2];
            if (dp_updates_cv(w_cmd)) begin
                r_flags[1:0] <= i_alu_flags[1:0];
            end
        end
    end

    // Next-state and per-state datapath controls
    always_comb begin
        w_next_state = r_state;
        w_pc_write   = 1'b0;
        w_ir_write   = 1'b0;
        w_reg_write  = 1'b0;
        w_mem_write  = 1'b0;
        w_flag_write = 1'b0;
        w_adr_src    = 1'b0;
        w_alu_src_a  = 1'b0;
        w_alu_src_b  = SRCB_RM;
        w_result_src = RES_ALUOUT;
        w_alu_ctrl   = ALU_ADD;
        case (r_state)
            S_FETCH: begin
                w_alu_src_a  = 1'b1;
                w_alu_src_b  = SRCB_FOUR;
                w_result_src = RES_ALU;
                if (i_mem_ready) begin
                    w_ir_write   = 1'b1;
                    w_pc_write   = 1'b1;
                    w_next_state = S_DECODE;
                end
            end
            S_DECODE: begin
                w_alu_src_a  = 1'b1;
                w_alu_src_b  = SRCB_FOUR;
                w_result_src = RES_ALU;
                if (!w_cond_ex || (w_op == OP_UND)) begin
                    w_next_state = S_FETCH;
                end else begin
                    case (w_op)
                        OP_MEM:  w_next_state = S_MEMADR;
                        OP_BR:   w_next_state = S_BRANCH;
                        OP_DP:   w_next_state = w_i ? S_EXECUTEI : S_EXECUTER;
                        default: w_next_state = S_FETCH;
                    endcase
                end
            end
            S_EXECUTER, S_EXECUTEI: begin
                w_alu_src_b  = (r_state == S_EXECUTEI) ? SRCB_EXT : SRCB_RM;
                w_alu_ctrl   = dp_alu_ctrl(w_cmd);
                w_flag_write = w_cmd_valid && (w_sl || w_is_cmp);
                w_next_state = S_ALUWB;
            end
            S_ALUWB: begin
                w_result_src = RES_ALUOUT;
                w_reg_write  = w_cmd_valid && !w_is_cmp;
                w_next_state = S_FETCH;
            end
            S_MEMADR: begin
                w_alu_src_b  = SRCB_EXT;
                w_alu_ctrl   = w_u ? ALU_ADD : ALU_SUB;
                w_next_state = w_sl ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                w_adr_src = 1'b1;
                if (i_mem_ready) begin
                    w_next_state = S_MEMWB;
                end
            end
            S_MEMWB: begin
                w_result_src = RES_RDATA;
                w_reg_write  = 1'b1;
                w_next_state = S_FETCH;
            end
            S_MEMWRITE: begin
                w_adr_src   = 1'b1;
                w_mem_write = 1'b1;
                if (i_mem_ready) begin
                    w_next_state = S_FETCH;
                end
            end
            S_BRANCH: begin
                w_alu_src_b  = SRCB_EXT;
                w_alu_ctrl   = ALU_ADD;
                w_result_src = RES_ALU;
                w_pc_write   = 1'b1;
                w_next_state = S_FETCH;
            end
            default: begin
                w_next_state = S_FETCH;
            end
        endcase
    end

    // Write enables are killed combinationally so a reset stops stores in the same cycle
    assign o_pc_write   = w_pc_write  & ~i_rst;
    assign o_ir_write   = w_ir_write  & ~i_rst;
    assign o_reg_write  = w_reg_write & ~i_rst;
    assign o_mem_write  = w_mem_write & ~i_rst;
    assign o_adr_src    = w_adr_src;
    assign o_alu_src_a  = w_alu_src_a;
    assign o_alu_src_b  = w_alu_src_b;
    assign o_result_src = w_result_src;
    assign o_alu_ctrl   = w_alu_ctrl;
    assign o_imm_src    = w_op;
    assign o_reg_src    = {(w_op == OP_MEM) && !w_sl, (w_op == OP_BR)};
    assign o_flags      = r_flags;
    assign o_state      = r_state;

endmodule

// File: tb/tb_multicycle_controller.sv
// tb/tb_multicycle_controller.sv - directed self-checking bench for multicycle_controller
module tb_multicycle_controller;
    import cpu_ctrl_pkg::*;

    logic        clk;
    logic        rst;
    logic [31:0] instr;
    logic [3:0]  alu_flags;
    logic        mem_ready;
    logic        pc_write;
    logic        ir_write;
    logic        reg_write;
    logic        mem_write;
    logic        adr_src;
    logic        alu_src_a;
    logic [1:0]  alu_src_b;
    logic [1:0]  result_src;
    logic [2:0]  alu_ctrl;
    logic [1:0]  imm_src;
    logic [1:0]  reg_src;
    logic [3:0]  flags;
    logic [3:0]  state;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    multicycle_controller dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_instr      (instr),
        .i_alu_flags  (alu_flags),
        .i_mem_ready  (mem_ready),
        .o_pc_write   (pc_write),
        .o_ir_write   (ir_write),
        .o_reg_write  (reg_write),
        .o_mem_write  (mem_write),
        .o_adr_src    (adr_src),
        .o_alu_src_a  (alu_src_a),
        .o_alu_src_b  (alu_src_b),
        .o_result_src (result_src),
        .o_alu_ctrl   (alu_ctrl),
        .o_imm_src    (imm_src),
        .o_reg_src    (reg_src),
        .o_flags      (flags),
        .o_state      (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish before 200000");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; lands mid-cycle on the falling edge
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Completes a FETCH with memory ready; returns in DECODE
    task automatic do_fetch(input logic [31:0] ins);
        instr     = ins;
        mem_ready = 1'b1;
        #1;
        chk("fetch_state", 32'(state), 32'(S_FETCH));
        chk("fetch_irw", 32'(ir_write), 1);
        tick();
        #1;
        chk("decode_state", 32'(state), 32'(S_DECODE));
    endtask

    initial begin
        rst       = 1'b1;
        instr     = 32'h0;
        alu_flags = 4'h0;
        mem_ready = 1'b1;
        tick();
        tick();
        #1;
        chk("rst_state", 32'(state), 32'(S_FETCH));
        chk("rst_flags", 32'(flags), 0);
        chk("rst_pcw", 32'(pc_write), 0);
        chk("rst_irw", 32'(ir_write), 0);
        chk("rst_srca", 32'(alu_src_a), 1);
        chk("rst_srcb", 32'(alu_src_b), 2);
        chk("rst_res", 32'(result_src), 2);
        rst = 1'b0;

        // MOV r0,#0: FETCH, DECODE, EXECUTEI, ALUWB
        do_fetch(32'he3a00000);
        chk("mov_dec_pcw", 32'(pc_write), 0);
        tick(); #1;
        chk("mov_exe_state", 32'(state), 32'(S_EXECUTEI));
        chk("mov_exe_alu", 32'(alu_ctrl), 4);
        chk("mov_exe_srcb", 32'(alu_src_b), 1);
        chk("mov_exe_srca", 32'(alu_src_a), 0);
        tick(); #1;
        chk("mov_wb_state", 32'(state), 32'(S_ALUWB));
        chk("mov_wb_regw", 32'(reg_write), 1);
        chk("mov_wb_res", 32'(result_src), 0);
        tick(); #1;
        chk("mov_done", 32'(state), 32'(S_FETCH));

        // LDR with two stall cycles in MEMREAD: 7 cycles total
        do_fetch(32'he5901000);
        chk("ldr_imm_src", 32'(imm_src), 1);
        tick(); #1;
        chk("ldr_adr_state", 32'(state), 32'(S_MEMADR));
        chk("ldr_adr_alu", 32'(alu_ctrl), 0);
        chk("ldr_adr_srcb", 32'(alu_src_b), 1);
        mem_ready = 1'b0;
        tick(); #1;
        chk("ldr_rd1_state", 32'(state), 32'(S_MEMREAD));
        chk("ldr_rd1_adr", 32'(adr_src), 1);
        tick(); #1;
        chk("ldr_rd2_state", 32'(state), 32'(S_MEMREAD));
        chk("ldr_rd2_adr", 32'(adr_src), 1);
        mem_ready = 1'b1;
        #1;
        chk("ldr_rd3_state", 32'(state), 32'(S_MEMREAD));
        chk("ldr_rd3_adr", 32'(adr_src), 1);
        tick(); #1;
        chk("ldr_wb_state", 32'(state), 32'(S_MEMWB));
        chk("ldr_wb_res", 32'(result_src), 1);
        chk("ldr_wb_regw", 32'(reg_write), 1);
        tick(); #1;
        chk("ldr_done", 32'(state), 32'(S_FETCH));

        // CMP r1,#0xFF sets Z; no register write
        do_fetch(32'he35100ff);
        tick();
        alu_flags = 4'b0100;
        #1;
        chk("cmp_exe_alu", 32'(alu_ctrl), 1);
        chk("cmp_exe_regw", 32'(reg_write), 0);
        chk("cmp_exe_flags", 32'(flags), 0);
        tick(); #1;
        chk("cmp_wb_flags", 32'(flags), 4);
        chk("cmp_wb_regw", 32'(reg_write), 0);
        tick(); #1;
        chk("cmp_done", 32'(state), 32'(S_FETCH));

        // BEQ taken
        do_fetch(32'h0a00003f);
        chk("beq_reg_src", 32'(reg_src), 1);
        tick(); #1;
        chk("beq_state", 32'(state), 32'(S_BRANCH));
        chk("beq_pcw", 32'(pc_write), 1);
        chk("beq_srca", 32'(alu_src_a), 0);
        chk("beq_srcb", 32'(alu_src_b), 1);
        chk("beq_res", 32'(result_src), 2);
        tick(); #1;
        chk("beq_done", 32'(state), 32'(S_FETCH));

        // CMP clearing flags, then BEQ not taken
        do_fetch(32'he35100ff);
        tick();
        alu_flags = 4'b0000;
        tick(); #1;
        chk("cmp2_flags", 32'(flags), 0);
        tick();
        do_fetch(32'h0a00003f);
        chk("beqn_dec_pcw", 32'(pc_write), 0);
        tick(); #1;
        chk("beqn_state", 32'(state), 32'(S_FETCH));

        // ANDS: N/Z follow the ALU, C/V held
        do_fetch(32'he2100000);
        tick();
        alu_flags = 4'b1111;
        #1;
        chk("ands_alu", 32'(alu_ctrl), 2);
        tick(); #1;
        chk("ands_flags", 32'(flags), 4'hc);
        chk("ands_regw", 32'(reg_write), 1);
        tick();

        // Unsupported cmd with S=1 is a NOP: flags untouched, no register write
        do_fetch(32'he0300000);
        tick();
        alu_flags = 4'b0000;
        #1;
        chk("nop_state", 32'(state), 32'(S_EXECUTER));
        chk("nop_srcb", 32'(alu_src_b), 0);
        tick(); #1;
        chk("nop_regw", 32'(reg_write), 0);
        chk("nop_flags", 32'(flags), 4'hc);
        tick();

        // STR with three stall cycles in MEMWRITE
        do_fetch(32'he5804000);
        chk("str_reg_src", 32'(reg_src), 2);
        tick();
        mem_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick(); #1;
            chk("str_stall_memw", 32'(mem_write), 1);
            chk("str_stall_state", 32'(state), 32'(S_MEMWRITE));
        end
        mem_ready = 1'b1;
        #1;
        chk("str_last_memw", 32'(mem_write), 1);
        tick(); #1;
        chk("str_done", 32'(state), 32'(S_FETCH));
        chk("str_done_memw", 32'(mem_write), 0);

        // Reset during a stalled MEMWRITE aborts it at once
        do_fetch(32'he5804000);
        tick();
        mem_ready = 1'b0;
        tick(); #1;
        chk("abort_pre_memw", 32'(mem_write), 1);
        chk("abort_pre_flags", 32'(flags), 4'hc);
        rst = 1'b1;
        #1;
        chk("abort_memw", 32'(mem_write), 0);
        chk("abort_state", 32'(state), 32'(S_FETCH));
        chk("abort_flags", 32'(flags), 0);
        tick();
        rst = 1'b0;

        // cond=1111 and op=11 each take two cycles
        do_fetch(32'hf3a00000);
        tick(); #1;
        chk("nv_done", 32'(state), 32'(S_FETCH));
        do_fetch(32'hec000000);
        tick(); #1;
        chk("op11_done", 32'(state), 32'(S_FETCH));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Control sequencer for the multicycle ARM-subset CPU. It decodes the latched instruction word, evaluates its condition field against an internal NZCV flags register, and steps the datapath through fetch/decode/execute/memory/writeback states. It drives every datapath mux select and write enable, and stalls on a memory-ready handshake. It sits between the instruction register and the shared datapath (register file, ALU, unified memory port).

## Interface
- No parameters; encodings are fixed in the package.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `instr` in 32: current IR contents. Stable from DECODE until the next FETCH.
- `alu_flags` in 4: NZCV from the ALU in the current cycle.
- `mem_ready` in 1: memory completes the access this cycle.
- `pc_write`, `ir_write`, `reg_write`, `mem_write` out 1: write enables.
- `adr_src` out 1: 0 = PC, 1 = ALU result register.
- `alu_src_a` out 1: 0 = Rn, 1 = PC.
- `alu_src_b` out 2: 00 = Rm, 01 = ExtImm, 10 = constant 4.
- `result_src` out 2: 00 = ALUOut reg, 01 = read data, 10 = ALU direct.
- `alu_ctrl` out 3: 000 ADD, 001 SUB, 010 AND, 011 ORR, 100 PASS_B.
- `imm_src` out 2 = `instr[27:26]`.
- `reg_src` out 2: [0] = branch (read R15), [1] = store (Rd on port 2).
- `flags` out 4: stored NZCV.
- `state` out 4: debug.

## Operation
- Fields: op = `instr[27:26]`, I = [25], cmd = [24:21], S/L = [20], U = [23], cond = [31:28].
- Data processing (op 00):
  - ADD 0100 → ADD; SUB 0010 → SUB; AND 0000 → AND; ORR 1100 → ORR; MOV 1101 → PASS_B; CMP 1010 → SUB with forced flag write and no register write.
  - Any other cmd is a NOP: no register write, no flag write.
- Flag write happens in the EXECUTER/EXECUTEI edge when S=1 or cmd is CMP.
  - N and Z are always updated.
  - C and V are updated only for ADD, SUB and CMP.
- Condition evaluation (`cond_ex`, against `flags`):
  - EQ Z; NE !Z; CS C; CC !C; MI N; PL !N; VS V; VC !V.
  - HI C&!Z; LS !C|Z; GE N==V; LT N!=V; GT !Z&(N==V); LE Z|(N!=V); AL 1; 1111 → 0.
- States and transitions:
  - FETCH: adr_src=0, alu_src_a=1, alu_src_b=10, ADD, result_src=10. While `mem_ready`=0: hold, with ir_write/pc_write=0. When `mem_ready`=1: ir_write=pc_write=1, go to DECODE.
  - DECODE: alu_src_a=1, alu_src_b=10, ADD, result_src=10. Next state:
    - `cond_ex`=0 or op=11 → FETCH.
    - op=01 → MEMADR.
    - op=10 → BRANCH.
    - op=00 → EXECUTEI if I=1, else EXECUTER.
  - EXECUTER (alu_src_b=00) / EXECUTEI (alu_src_b=01): alu_src_a=0, alu_ctrl per cmd, flag write as above. Next state is ALUWB.
  - ALUWB: result_src=00; reg_write=1 unless CMP or NOP. Next state is FETCH.
  - MEMADR: alu_src_a=0, alu_src_b=01, ADD if U=1 else SUB. Next state is MEMREAD if L=1, else MEMWRITE.
  - MEMREAD: adr_src=1. Hold until `mem_ready`, then go to MEMWB.
  - MEMWB: result_src=01, reg_write=1. Next state is FETCH.
  - MEMWRITE: adr_src=1, mem_write=1 held until `mem_ready`, then go to FETCH.
  - BRANCH: alu_src_a=0, alu_src_b=01, ADD, result_src=10, pc_write=1. Next state is FETCH.
- Any signal not listed for a state is 0.
- Condition is checked only in DECODE. Flags cannot change between DECODE and writeback, so later states are unconditional.

## Timing
- Latency with `mem_ready` held at 1:
  - DP: 4 cycles.
  - LDR: 5 cycles.
  - STR: 4 cycles.
  - Taken B: 3 cycles.
  - Failed condition or op=11: 2 cycles.
- Each cycle of `mem_ready`=0 in FETCH, MEMREAD or MEMWRITE adds one cycle. All outputs stay constant during a stall.
- `flags` updates on the clock edge that ends EXECUTE and is visible in ALUWB.
- Reset:
  - While `rst`=1: state=FETCH, flags=0000, and all four write enables forced to 0 combinationally. Mux selects take their FETCH values.
  - Reset asserted mid-instruction (including during a stalled MEMWRITE) aborts it immediately. `mem_write` drops in the same cycle.
- After `rst` deasserts, the first FETCH completes on the first edge with `mem_ready`=1.

## Structure
- `cpu_ctrl_pkg` holds the shared encodings:
  - `state_t` enum (10 states, 4 bits).
  - `alu_ctrl_t`.
  - Localparams for the src_b and result_src encodings.
  - Condition codes and the DP cmd codes.
- One combinational sub-module, `cond_unit` (cond, flags → cond_ex).
- FSM, main decoder and flags register are in `multicycle_controller`.

## Test plan
- `e3a00000` (MOV r0,#0), ready=1 → FETCH, DECODE, EXECUTEI, ALUWB. In cycle 3: alu_ctrl=100, alu_src_b=01. In cycle 4: reg_write=1, result_src=00.
- `e5901000` (LDR) with `mem_ready` low for 2 cycles in MEMREAD → 7 cycles total. adr_src=1 throughout MEMREAD. MEMWB has result_src=01 and reg_write=1.
- `e35100ff` (CMP r1,#0xFF) with alu_flags=0100 → flags=0100 after EXECUTEI and reg_write never asserted. Then `0a00003f` (BEQ) → BRANCH with pc_write=1. With flags=0000 instead, the same BEQ goes DECODE → FETCH and pc_write stays 0 outside FETCH.
- `e5804000` (STR) with ready low for 3 cycles → mem_write=1 for 4 cycles, reg_src=10 in DECODE, return to FETCH.
- Assert `rst` during a stalled MEMWRITE → mem_write=0 in the same cycle, state=FETCH, flags=0000. Instructions with cond=1111 and with op=11 each take exactly 2 cycles.
